// File: rtl/bitwise_gate_unit_if.sv
// rtl/bitwise_gate_unit_if.sv - handshake bundle for bitwise_gate_unit; GATE_ACCUM_EN adds acc_clr
interface bitwise_gate_unit_if #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 2
);
  logic                    in_valid;
  logic                    in_ready;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [2:0]              mode;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_any;
`ifdef GATE_ACCUM_EN
  logic                    acc_clr;

  modport master (
    output in_valid, in_data, mode, out_ready, acc_clr,
    input  in_ready, out_valid, out_data, out_any
  );
  modport slave (
    input  in_valid, in_data, mode, out_ready, acc_clr,
    output in_ready, out_valid, out_data, out_any
  );
`else
  modport master (
    output in_valid, in_data, mode, out_ready,
    input  in_ready, out_valid, out_data, out_any
  );
  modport slave (
    input  in_valid, in_data, mode, out_ready,
    output in_ready, out_valid, out_data, out_any
  );
`endif
endinterface

// File: rtl/bitwise_gate_unit.sv
// rtl/bitwise_gate_unit.sv - registered NUM_IN-operand bitwise gate with 2-entry skid buffer
// Optional accumulate modes 6/7 enabled by GATE_ACCUM_EN.
module bitwise_gate_unit #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  bitwise_gate_unit_if.slave  bus
);

  // State encoding is {a_valid, b_valid}, so handshake outputs are plain state bits.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_data, b_data;
  logic             a_any, b_any;
  logic [WIDTH-1:0] or_r, and_r, xor_r, result;
  logic             accept, drain;
  logic             load_a_new, load_b_new, move_b;

  assign bus.in_ready  = ~state[0];
  assign bus.out_valid = state[1];
  assign bus.out_data  = a_data;
  assign bus.out_any   = a_any;

  assign accept = bus.in_valid & ~state[0];
  assign drain  = state[1] & bus.out_ready;

  always_comb begin
    or_r  = '0;
    and_r = '1;
    xor_r = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      or_r  = or_r  | bus.in_data[k*WIDTH +: WIDTH];
      and_r = and_r & bus.in_data[k*WIDTH +: WIDTH];
      xor_r = xor_r ^ bus.in_data[k*WIDTH +: WIDTH];
    end
  end

`ifdef GATE_ACCUM_EN
  logic [WIDTH-1:0] acc, acc_eff;

  // acc_clr in the accepting cycle makes the accumulate start from zero.
  assign acc_eff = bus.acc_clr ? '0 : acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (accept && bus.mode[2:1] == 2'b11) begin
      acc <= result;
    end else if (bus.acc_clr) begin
      acc <= '0;
    end
  end
`endif

  always_comb begin
    result = '0;
    case (bus.mode)
      3'd0: result = or_r;
      3'd1: result = and_r;
      3'd2: result = xor_r;
      3'd3: result = ~or_r;
      3'd4: result = ~and_r;
      3'd5: result = ~xor_r;
`ifdef GATE_ACCUM_EN
      3'd6: result = or_r | acc_eff;
      3'd7: result = xor_r ^ acc_eff;
`else
      3'd6: result = '0;
      3'd7: result = '0;
`endif
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    load_a_new = 1'b0;
    load_b_new = 1'b0;
    move_b     = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt  = ONE;
          load_a_new = 1'b1;
        end
      end
      ONE: begin
        if (accept && drain) begin
          load_a_new = 1'b1;
        end else if (accept) begin
          state_nxt  = FULL;
          load_b_new = 1'b1;
        end else if (drain) begin
          state_nxt  = EMPTY;
        end
      end
      FULL: begin
        if (drain) begin
          state_nxt = ONE;
          move_b    = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_data <= '0;
      a_any  <= 1'b0;
      b_data <= '0;
      b_any  <= 1'b0;
    end else begin
      if (load_a_new) begin
        a_data <= result;
        a_any  <= |result;
      end else if (move_b) begin
        a_data <= b_data;
        a_any  <= b_any;
      end
      if (load_b_new) begin
        b_data <= result;
        b_any  <= |result;
      end
    end
  end

endmodule

// File: tb/tb_bitwise_gate_unit.sv
// tb/tb_bitwise_gate_unit.sv - randomized scoreboard bench for bitwise_gate_unit (NUM_IN=3, WIDTH=8)
module tb_bitwise_gate_unit;

  localparam int W = 8;
  localparam int N = 3;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  logic [W-1:0] q[$];
  logic [W-1:0] model_acc;

  bitwise_gate_unit_if #(.WIDTH(W), .NUM_IN(N)) bus ();

  bitwise_gate_unit #(.WIDTH(W), .NUM_IN(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Per-bit population count over operands, then classify by count.
  function automatic logic [W-1:0] ref_gate(input logic [N*W-1:0] d, input logic [2:0] m,
                                           input logic [W-1:0] acc_prime);
    logic [W-1:0] r;
    r = '0;
    for (int b = 0; b < W; b++) begin
      int cnt;
      logic o, a, x;
      cnt = 0;
      for (int k = 0; k < N; k++) cnt += int'(d[k*W + b]);
      o = (cnt > 0);
      a = (cnt == N);
      x = (cnt % 2) == 1;
      case (m)
        3'd0: r[b] = o;
        3'd1: r[b] = a;
        3'd2: r[b] = x;
        3'd3: r[b] = !o;
        3'd4: r[b] = !a;
        3'd5: r[b] = !x;
`ifdef GATE_ACCUM_EN
        3'd6: r[b] = o || acc_prime[b];
        3'd7: r[b] = x != acc_prime[b];
`else
        default: r[b] = 1'b0;
`endif
      endcase
    end
`ifndef GATE_ACCUM_EN
    if (acc_prime != acc_prime) r = 'x;
`endif
    return r;
  endfunction

  task automatic set_in(input logic vld, input logic [W-1:0] o2, input logic [W-1:0] o1,
                        input logic [W-1:0] o0, input logic [2:0] m);
    bus.in_valid = vld;
    bus.in_data  = {o2, o1, o0};
    bus.mode     = m;
  endtask

  // One scoreboarded cycle: the queue is the expected FIFO content of the unit.
  task automatic cycle();
    logic         acc_vld, drn, clr;
    logic [W-1:0] exp, acc_prime;
    check("occ_out_valid", bus.out_valid, q.size() != 0);
    check("occ_in_ready", bus.in_ready, q.size() < 2);
    drn     = bus.out_valid && bus.out_ready;
    acc_vld = bus.in_valid && bus.in_ready;
`ifdef GATE_ACCUM_EN
    clr = bus.acc_clr;
`else
    clr = 1'b0;
`endif
    if (drn) begin
      if (q.size() == 0) begin
        check("spurious_out", 1, 0);
      end else begin
        exp = q.pop_front();
        check("sb_data", bus.out_data, exp);
        check("sb_any", bus.out_any, |exp);
      end
    end
    acc_prime = clr ? '0 : model_acc;
    if (acc_vld) begin
      exp = ref_gate(bus.in_data, bus.mode, acc_prime);
      q.push_back(exp);
      if (bus.mode >= 3'd6) model_acc = exp;
      else if (clr) model_acc = '0;
    end else if (clr) begin
      model_acc = '0;
    end
    step();
  endtask

  logic [W-1:0] mode_exp [6];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    model_acc = '0;
    mode_exp = '{8'hFE, 8'h80, 8'h96, 8'h01, 8'h7F, 8'h69};
    rst_n = 1'b0;
    set_in(1'b0, 8'h00, 8'h00, 8'h00, 3'd0);
    bus.out_ready = 1'b0;
`ifdef GATE_ACCUM_EN
    bus.acc_clr = 1'b0;
`endif
    step();
    step();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_any", bus.out_any, 0);
    check("rst_in_ready", bus.in_ready, 1);
    rst_n = 1'b1;
    step();

    // Basic OR
    bus.out_ready = 1'b1;
    set_in(1'b1, 8'h00, 8'hF0, 8'h0F, 3'd0);
    step();
    check("or_valid", bus.out_valid, 1);
    check("or_data", bus.out_data, 8'hFF);
    check("or_any", bus.out_any, 1);

    // All fixed modes over three operands
    for (int m = 0; m < 6; m++) begin
      set_in(1'b1, 8'hCC, 8'hAA, 8'hF0, 3'(m));
      step();
      check($sformatf("mode%0d_data", m), bus.out_data, mode_exp[m]);
      check($sformatf("mode%0d_any", m), bus.out_any, |mode_exp[m]);
    end
    bus.in_valid = 1'b0;
    step();
    check("idle_valid", bus.out_valid, 0);

    // Backpressure
    bus.out_ready = 1'b0;
    set_in(1'b1, 8'h00, 8'h00, 8'h11, 3'd0);
    step();
    check("bp_ready_after1", bus.in_ready, 1);
    set_in(1'b1, 8'h00, 8'h00, 8'h22, 3'd0);
    step();
    check("bp_ready_after2", bus.in_ready, 0);
    set_in(1'b1, 8'h00, 8'h00, 8'h33, 3'd0);
    step();
    check("bp_hold_data", bus.out_data, 8'h11);
    check("bp_hold_ready", bus.in_ready, 0);
    step();
    check("bp_hold_data2", bus.out_data, 8'h11);
    bus.out_ready = 1'b1;
    step();
    check("bp_out2", bus.out_data, 8'h22);
    step();
    check("bp_out3", bus.out_data, 8'h33);
    check("bp_out3_valid", bus.out_valid, 1);
    bus.in_valid = 1'b0;
    step();
    check("bp_no_dup", bus.out_valid, 0);

    // Async reset from FULL
    bus.out_ready = 1'b0;
    set_in(1'b1, 8'h00, 8'h00, 8'h5A, 3'd0);
    step();
    step();
    check("ar_full", bus.in_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_out_valid", bus.out_valid, 0);
    check("ar_in_ready", bus.in_ready, 1);
    check("ar_out_data", bus.out_data, 0);
    bus.in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check("ar_post_valid", bus.out_valid, 0);
    check("ar_post_data", bus.out_data, 0);

    // Accumulate modes
    bus.out_ready = 1'b1;
`ifdef GATE_ACCUM_EN
    set_in(1'b1, 8'h00, 8'h00, 8'h01, 3'd6);
    step();
    check("acc_1", bus.out_data, 8'h01);
    set_in(1'b1, 8'h00, 8'h00, 8'h04, 3'd6);
    step();
    check("acc_2", bus.out_data, 8'h05);
    set_in(1'b1, 8'h00, 8'h00, 8'h02, 3'd6);
    bus.acc_clr = 1'b1;
    step();
    check("acc_clr", bus.out_data, 8'h02);
    bus.acc_clr = 1'b0;
    bus.in_valid = 1'b0;
    step();
    bus.acc_clr = 1'b1;
    step();
    bus.acc_clr = 1'b0;
    model_acc = '0;
`else
    set_in(1'b1, 8'h00, 8'hF0, 8'h0F, 3'd6);
    step();
    check("noacc6_data", bus.out_data, 8'h00);
    check("noacc6_any", bus.out_any, 0);
    set_in(1'b1, 8'h00, 8'hF0, 8'h0F, 3'd7);
    step();
    check("noacc7_data", bus.out_data, 8'h00);
    bus.in_valid = 1'b0;
`endif
    step();

    // Full-rate stream with simultaneous accept and drain
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_in(1'b1, 8'($urandom()), 8'($urandom()), 8'($urandom()), 3'($urandom_range(0, 5)));
      check("stream_in_ready", bus.in_ready, 1);
      cycle();
    end

    // Randomized traffic with backpressure
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom_range(0, 3) != 0), 8'($urandom()), 8'($urandom()), 8'($urandom()),
             3'($urandom_range(0, 7)));
      bus.out_ready = ($urandom_range(0, 2) != 0);
`ifdef GATE_ACCUM_EN
      bus.acc_clr = ($urandom_range(0, 9) == 0);
`endif
      cycle();
    end

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
`ifdef GATE_ACCUM_EN
    bus.acc_clr = 1'b0;
`endif
    for (int i = 0; i < 8 && q.size() != 0; i++) cycle();
    check("drain_empty", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bitwise_gate_unit.md
# bitwise_gate_unit

Parametrised, registered multi-input bitwise logic unit: the successor to the single two-input OR gate. Combines NUM_IN operands of WIDTH bits under a per-transaction selectable gate mode. Uses a valid/ready handshake with a two-entry output skid buffer, so it can sit inside pipelined datapaths such as the partial-product combining stages of the vedic multiplier. An optional accumulate mode keeps a running result across transactions.

## Interface
- WIDTH, 8, bit width of each operand and of the result (≥1)
- NUM_IN, 2, number of operands combined per transaction (≥2)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand set and mode are valid
- in_ready  out  1  unit can accept a transaction this cycle
- in_data  in  NUM_IN*WIDTH  operands; operand k is bits [k*WIDTH +: WIDTH]
- mode  in  3  gate select, sampled with in_data
- out_valid  out  1  out_data is valid
- out_ready  in  1  downstream accepts out_data this cycle
- out_data  out  WIDTH  gate result
- out_any  out  1  reduction OR of out_data
- acc_clr  in  1  clears the accumulator; present only with GATE_ACCUM_EN

## Operation
- Transfer on an interface occurs when valid and ready are both high at a rising clk edge.
- Modes, applied bitwise across all NUM_IN operands:
  - 0: OR
  - 1: AND
  - 2: XOR (odd parity per bit)
  - 3: NOR
  - 4: NAND
  - 5: XNOR (inverse of mode 2)
  - 6: ACC_OR
  - 7: ACC_XOR
- Result is computed at input acceptance and stored with its out_any flag.
- Storage:
  - Output register (slot A) drives out_data/out_valid.
  - Skid register (slot B) catches one transaction accepted while A is stalled.
  - FIFO order is strict: B moves to A when A is consumed.
- in_ready = !B_valid, driven from a register with no combinational path from out_ready.
- States, encoded by (A_valid, B_valid):
  - EMPTY(0,0): accept → ONE
  - ONE(1,0): accept without out transfer → FULL; out transfer without accept → EMPTY; both → ONE, A takes new data
  - FULL(1,1): out transfer → ONE, A←B; input is not accepted
- Simultaneous accept and out transfer in ONE must not drop or duplicate data.
- Inputs are ignored while in_ready is low, even if in_valid is high.
- Reset mid-operation discards A, B and the accumulator.

## Timing
- Latency: a transaction accepted at edge t appears on out_data with out_valid high after edge t (one cycle).
- Throughput: one transaction per cycle while out_ready is held high.
- Under backpressure, in_ready falls one cycle after the second transaction is accepted into a stalled unit.
- out_data and out_any hold stable while out_valid=1 and out_ready=0.
- Reset values: out_valid=0, out_data=0, out_any=0, in_ready=1, accumulator=0.

## Configuration
- Macro: GATE_ACCUM_EN.
- Defined:
  - A WIDTH-bit accumulator ACC is added, along with port acc_clr.
  - Mode 6 result = (OR of operands) | ACC'.
  - Mode 7 result = (XOR of operands) ^ ACC'.
  - ACC' is 0 if acc_clr=1 in the accepting cycle, else ACC.
  - ACC ← result on each accepted mode 6/7 transaction.
  - acc_clr without an accepted ACC transaction sets ACC=0 at the next edge.
  - Modes 0–5 never change ACC.
- Undefined: modes 6 and 7 return 0 (out_any=0), there is no accumulator and no acc_clr port.

## Test plan
- Reset and basic OR: after rst_n release, WIDTH=8, NUM_IN=2, mode 0, in_data={8'hF0,8'h0F}, out_ready=1 → next cycle out_valid=1, out_data=8'hFF, out_any=1; reset values checked first.
- All modes, NUM_IN=3: operands 8'hCC, 8'hAA, 8'hF0 →
  - mode 0: 8'hFE
  - mode 1: 8'h80
  - mode 2: 8'h96
  - mode 3: 8'h01
  - mode 4: 8'h7F
  - mode 5: 8'h69
- Backpressure:
  - Setup: out_ready=0, stream results 8'h11, 8'h22, 8'h33 with in_valid held high.
  - in_ready drops after two acceptances and 8'h33 is held off.
  - Raising out_ready yields 8'h11, 8'h22, 8'h33 in order, with no loss or duplication.
- Simultaneous accept and drain in ONE state: continuous stream at 1/cycle with out_ready=1 → every result appears exactly once, in_ready never drops.
- Async reset mid-transfer: assert rst_n low in FULL state between edges → out_valid=0 and in_ready=1 immediately; no stale data after release.
- Accumulate (GATE_ACCUM_EN):
  - mode 6 with {8'h01,8'h00}, then {8'h04,8'h00} → 8'h01, 8'h05.
  - Next mode 6 {8'h02,8'h00} with acc_clr=1 → 8'h02.
  - Without the macro, mode 6 → 8'h00.
